// File: rtl/tick_pkg.sv
// Shared constants for the tick divider: state encoding and board clock rate.
// The default divisor is derived from the board clock so that one tick is 1 s.
package tick_pkg;

  localparam longint unsigned BOARD_CLK_HZ = 64'd100_000_000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/tick_divider.sv
// Clock-enable divider: emits one CEO pulse every div_q CE ticks, periodic or one-shot.
// state | meaning
// IDLE  | not counting; one-shot waiting for start, or first cycle after reset
// RUN   | counting CE ticks toward terminal count div_q-1
module tick_divider
  import tick_pkg::*;
#(
  parameter int unsigned      WIDTH       = 27,
  parameter longint unsigned  DIV_DEFAULT = BOARD_CLK_HZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CE,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             oneshot,
  input  logic             start,
  output logic [WIDTH-1:0] counter,
  output logic             CEO,
  output logic             busy,
  output logic [WIDTH-1:0] div_q
);

  if (DIV_DEFAULT >= (64'd1 << WIDTH)) begin : g_div_default_too_wide
    $error("tick_divider: DIV_DEFAULT does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_RST = (DIV_DEFAULT == 0) ? ONE : WIDTH'(DIV_DEFAULT);

  logic [0:0]       r_state;
  logic             r_oneshot;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div;

  logic             w_term;
  logic             w_restart;
  logic             w_mode_chg;
  logic [WIDTH-1:0] w_div_new;

  assign w_term     = (r_count == (r_div - ONE));
  assign w_restart  = r_oneshot && start;
  assign w_mode_chg = (oneshot != r_oneshot);
  assign w_div_new  = (div_in == '0) ? ONE : div_in;

  // A restart strobe suppresses the pulse even if it lands on terminal count.
  assign CEO = (r_state == ST_RUN) && CE && w_term && !reset && !load && !w_restart;

  always_ff @(posedge clk) begin
    r_oneshot <= oneshot;
    if (reset) begin
      r_count <= '0;
      r_div   <= DIV_RST;
      r_state <= ST_IDLE;
    end else begin
      if (load) begin
        r_div <= w_div_new;
      end
      if (w_mode_chg) begin
        r_count <= '0;
        r_state <= oneshot ? ST_IDLE : ST_RUN;
      end else if (load) begin
        r_count <= '0;
        r_state <= r_oneshot ? ST_IDLE : ST_RUN;
      end else if (w_restart) begin
        r_count <= '0;
        r_state <= ST_RUN;
      end else if (CEO) begin
        r_count <= '0;
        if (r_oneshot) begin
          r_state <= ST_IDLE;
        end
      end else if ((r_state == ST_RUN) && CE) begin
        r_count <= r_count + ONE;
      end else if ((r_state == ST_IDLE) && !r_oneshot) begin
        r_state <= ST_RUN;
      end
    end
  end

  assign counter = r_count;
  assign div_q   = r_div;
  assign busy    = (r_state == ST_RUN);

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider: a reference model pushes expected CEO/state into
// queues each step; DUT outputs are popped and checked mid-cycle and after the edge.
module tb_tick_divider;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         busy;
    logic [W-1:0] div;
  } st_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         CE = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         oneshot = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] counter;
  logic         CEO;
  logic         busy;
  logic [W-1:0] div_q;

  tick_divider #(.WIDTH(W), .DIV_DEFAULT(5)) dut (
    .clk(clk), .reset(reset), .CE(CE), .load(load), .div_in(div_in),
    .oneshot(oneshot), .start(start), .counter(counter), .CEO(CEO),
    .busy(busy), .div_q(div_q)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt = 0;

  logic   exp_ceo_q[$];
  st_t    exp_st_q[$];
  int     pulse_q[$];
  int     pcnt_q[$];

  logic [W-1:0] m_cnt = '0;
  logic [W-1:0] m_div = 8'd5;
  logic         m_run = 1'b0;
  logic         m_os = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock step: drive, model, then check CEO mid-cycle and state after the edge.
  task automatic tick(input logic ce, input logic ld = 1'b0,
                      input logic [W-1:0] din = '0, input logic st = 1'b0);
    logic e_ceo;
    st_t  e_st;
    logic [W-1:0] n_cnt, n_div;
    logic n_run;
    logic e_cur;
    st_t  s;
    CE = ce; load = ld; div_in = din; start = st;
    e_ceo = !reset && !ld && m_run && ce && (m_cnt == m_div - 8'd1) && !(m_os && st);
    n_cnt = m_cnt; n_div = m_div; n_run = m_run;
    if (reset) begin
      n_cnt = '0; n_div = 8'd5; n_run = 1'b0;
    end else begin
      if (ld) n_div = (din == '0) ? 8'd1 : din;
      if (oneshot != m_os) begin
        n_cnt = '0; n_run = !oneshot;
      end else if (ld) begin
        n_cnt = '0; n_run = !m_os;
      end else if (m_os && st) begin
        n_cnt = '0; n_run = 1'b1;
      end else if (e_ceo) begin
        n_cnt = '0;
        if (m_os) n_run = 1'b0;
      end else if (m_run && ce) begin
        n_cnt = m_cnt + 8'd1;
      end else if (!m_run && !m_os) begin
        n_run = 1'b1;
      end
    end
    m_os = oneshot;
    m_cnt = n_cnt; m_div = n_div; m_run = n_run;
    e_st.cnt = n_cnt; e_st.busy = n_run; e_st.div = n_div;
    exp_ceo_q.push_back(e_ceo);
    exp_st_q.push_back(e_st);

    @(negedge clk);
    e_cur = exp_ceo_q.pop_front();
    chk("ceo", 32'(CEO), 32'(e_cur));
    if (CEO === 1'b1) begin
      pulse_q.push_back(cyc);
      pcnt_q.push_back(int'(counter));
    end
    @(posedge clk);
    #1;
    s = exp_st_q.pop_front();
    chk("counter", 32'(counter), 32'(s.cnt));
    chk("busy", 32'(busy), 32'(s.busy));
    chk("div_q", 32'(div_q), 32'(s.div));
    if (busy === 1'b1) busy_cnt++;
    cyc++;
  endtask

  task automatic clear_window();
    pulse_q.delete();
    pcnt_q.delete();
    busy_cnt = 0;
  endtask

  task automatic chk_spacing(input string tag, input int gap);
    for (int i = 1; i < pulse_q.size(); i++)
      chk(tag, 32'(pulse_q[i] - pulse_q[i-1]), 32'(gap));
  endtask

  int r_cyc;

  initial begin
    @(posedge clk);
    #1;
    // reset state
    reset = 1'b1; oneshot = 1'b0;
    tick(1'b0);
    tick(1'b1);
    chk("rst_counter", 32'(counter), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_div", 32'(div_q), 5);

    // periodic, CE held high
    reset = 1'b0;
    clear_window();
    for (int i = 0; i < 21; i++) tick(1'b1);
    chk("per_pulses", 32'(pulse_q.size()), 4);
    foreach (pcnt_q[i]) chk("per_pulse_cnt", 32'(pcnt_q[i]), 4);
    chk_spacing("per_spacing", 5);

    // CE toggling: pulse every 10 clocks
    clear_window();
    for (int i = 0; i < 20; i++) tick((i % 2) == 0);
    chk("tog_pulses", 32'(pulse_q.size()), 2);
    chk_spacing("tog_spacing", 10);

    // load 3 mid-period, then load 0
    tick(1'b1);
    tick(1'b1);
    chk("pre_load_cnt", 32'(counter), 2);
    tick(1'b1, 1'b1, 8'd3);
    chk("load3_cnt", 32'(counter), 0);
    chk("load3_div", 32'(div_q), 3);
    clear_window();
    for (int i = 0; i < 9; i++) tick(1'b1);
    chk("div3_pulses", 32'(pulse_q.size()), 3);
    chk_spacing("div3_spacing", 3);
    tick(1'b0, 1'b1, 8'd0);
    chk("load0_div", 32'(div_q), 1);
    clear_window();
    for (int i = 0; i < 4; i++) tick(1'b1);
    tick(1'b0);
    chk("div1_pulses", 32'(pulse_q.size()), 4);
    chk("div1_cnt", 32'(counter), 0);

    // reset mid-period
    tick(1'b0, 1'b1, 8'd5);
    for (int i = 0; i < 3; i++) tick(1'b1);
    chk("pre_rst_cnt", 32'(counter), 3);
    clear_window();
    reset = 1'b1;
    tick(1'b1);
    chk("midrst_pulses", 32'(pulse_q.size()), 0);
    chk("midrst_cnt", 32'(counter), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_div", 32'(div_q), 5);
    reset = 1'b0;

    // one-shot, divisor 4
    oneshot = 1'b1;
    tick(1'b0);
    chk("os_enter_busy", 32'(busy), 0);
    tick(1'b0, 1'b1, 8'd4);
    clear_window();
    tick(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) tick(1'b1);
    chk("os_pulses", 32'(pulse_q.size()), 1);
    chk("os_busy_cycles", 32'(busy_cnt), 4);
    chk("os_end_cnt", 32'(counter), 0);
    chk("os_end_busy", 32'(busy), 0);

    // one-shot restart at counter 2
    tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b1);
    tick(1'b1);
    chk("pre_restart_cnt", 32'(counter), 2);
    clear_window();
    r_cyc = cyc;
    tick(1'b1, 1'b0, '0, 1'b1);
    chk("restart_cnt", 32'(counter), 0);
    chk("restart_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) tick(1'b1);
    chk("restart_pulses", 32'(pulse_q.size()), 1);
    if (pulse_q.size() > 0) chk("restart_latency", 32'(pulse_q[0] - r_cyc), 4);

    // back to periodic: enters RUN immediately
    oneshot = 1'b0;
    tick(1'b0);
    chk("mode_per_busy", 32'(busy), 1);
    tick(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
